// File: rtl/message_arbiter.sv
// Round-robin arbiter sharing one message_build between NUM_REQ requesters.
// Grant is held from config handshake until the last data word is forwarded.
module message_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sync_rst,
   input  logic                     en,
   input  logic [NUM_REQ*64-1:0]    req_cfg_size,
   input  logic [NUM_REQ*2-1:0]     req_cfg_scheme,
   input  logic [NUM_REQ-1:0]       req_cfg_valid,
   output logic [NUM_REQ-1:0]       req_cfg_ready,
   input  logic [NUM_REQ*512-1:0]   req_data,
   input  logic [NUM_REQ-1:0]       req_data_last,
   input  logic [NUM_REQ-1:0]       req_data_valid,
   output logic [NUM_REQ-1:0]       req_data_ready,
   output logic [63:0]              cfg_size,
   output logic [1:0]               cfg_scheme,
   output logic                     cfg_valid,
   input  logic                     cfg_ready,
   output logic [511:0]             data_out,
   output logic                     data_out_last,
   output logic                     data_out_valid,
   input  logic                     data_out_ready,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic                     last_err
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_DATA} state_t;

   state_t             state_reg, state_next;
   logic [NUM_REQ-1:0] grant_reg;
   logic [IDXW-1:0]    gidx_reg;
   logic [IDXW-1:0]    rr_reg;
   logic [55:0]        count_reg;
   logic               last_err_reg;

   logic [IDXW-1:0]    pick_idx;
   logic               pick_found;
   int                 cand;
   logic [55:0]        words;
   logic [63:0]        sel_size;
   logic [1:0]         sel_scheme;
   logic [511:0]       sel_data;
   logic               sel_cfg_valid, sel_data_valid, sel_data_last;
   logic               in_cfg, in_data;
   logic               cfg_hs, data_hs, count_is_one;

   assign sel_size       = req_cfg_size[{gidx_reg, 6'b0} +: 64];
   assign sel_scheme     = req_cfg_scheme[{gidx_reg, 1'b0} +: 2];
   assign sel_data       = req_data[{gidx_reg, 9'b0} +: 512];
   assign sel_cfg_valid  = req_cfg_valid[gidx_reg];
   assign sel_data_valid = req_data_valid[gidx_reg];
   assign sel_data_last  = req_data_last[gidx_reg];

   assign in_cfg       = (state_reg == ST_CFG);
   assign in_data      = (state_reg == ST_DATA);
   assign count_is_one = (count_reg == 56'd1);
   assign cfg_hs       = in_cfg && sel_cfg_valid && cfg_ready;
   assign data_hs      = in_data && sel_data_valid && data_out_ready;

   // Walk downward so the candidate closest after rr_reg is the one that sticks.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = int'(rr_reg) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (req_cfg_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDXW'(cand);
         end
      end
   end

   // A zero-size message still occupies one word in message_build.
   always_comb begin
      words = {1'b0, sel_size[63:9]} + {55'd0, |sel_size[8:0]};
      if (words == 56'd0) words = 56'd1;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (en && pick_found) state_next = ST_CFG;
         ST_CFG:  if (cfg_hs) state_next = ST_DATA;
         ST_DATA: if (data_hs && count_is_one) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         grant_reg    <= '0;
         gidx_reg     <= '0;
         rr_reg       <= IDXW'(NUM_REQ - 1);
         count_reg    <= '0;
         last_err_reg <= 1'b0;
      end else if (sync_rst) begin
         state_reg    <= ST_IDLE;
         grant_reg    <= '0;
         gidx_reg     <= '0;
         rr_reg       <= IDXW'(NUM_REQ - 1);
         count_reg    <= '0;
         last_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (en && pick_found) begin
                  grant_reg <= NUM_REQ'(1) << pick_idx;
                  gidx_reg  <= pick_idx;
               end
            end
            ST_CFG: begin
               if (cfg_hs) count_reg <= words;
            end
            ST_DATA: begin
               if (data_hs) begin
                  count_reg    <= count_reg - 56'd1;
                  last_err_reg <= (sel_data_last != count_is_one);
                  if (count_is_one) begin
                     rr_reg    <= gidx_reg;
                     grant_reg <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_cfg_ready[gi]  = in_cfg && grant_reg[gi] && cfg_ready;
         assign req_data_ready[gi] = in_data && grant_reg[gi] && data_out_ready;
      end
   endgenerate

   assign cfg_size       = in_cfg ? sel_size : 64'd0;
   assign cfg_scheme     = in_cfg ? sel_scheme : 2'd0;
   assign cfg_valid      = in_cfg && sel_cfg_valid;
   assign data_out       = in_data ? sel_data : 512'd0;
   assign data_out_valid = in_data && sel_data_valid;
   assign data_out_last  = in_data && count_is_one;
   assign grant          = grant_reg;
   assign busy           = (state_reg != ST_IDLE);
   assign last_err       = last_err_reg;

endmodule

// File: tb/tb_message_arbiter.sv
// Randomized bench for message_arbiter: requester BFMs, transaction-level
// arbitration model and an end-to-end word scoreboard.
module tb_message_arbiter;
   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sync_rst = 1'b0;
   logic             en = 1'b0;
   logic [N*64-1:0]  req_cfg_size = '0;
   logic [N*2-1:0]   req_cfg_scheme = '0;
   logic [N-1:0]     req_cfg_valid = '0;
   logic [N-1:0]     req_cfg_ready;
   logic [N*512-1:0] req_data = '0;
   logic [N-1:0]     req_data_last = '0;
   logic [N-1:0]     req_data_valid = '0;
   logic [N-1:0]     req_data_ready;
   logic [63:0]      cfg_size;
   logic [1:0]       cfg_scheme;
   logic             cfg_valid;
   logic             cfg_ready = 1'b0;
   logic [511:0]     data_out;
   logic             data_out_last;
   logic             data_out_valid;
   logic             data_out_ready = 1'b0;
   logic [N-1:0]     grant;
   logic             busy;
   logic             last_err;

   message_arbiter #(.NUM_REQ(N)) dut (
      .clk(clk), .rst(rst), .sync_rst(sync_rst), .en(en),
      .req_cfg_size(req_cfg_size), .req_cfg_scheme(req_cfg_scheme),
      .req_cfg_valid(req_cfg_valid), .req_cfg_ready(req_cfg_ready),
      .req_data(req_data), .req_data_last(req_data_last),
      .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
      .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .data_out(data_out), .data_out_last(data_out_last),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .grant(grant), .busy(busy), .last_err(last_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // requester BFM state
   longint unsigned q_size[N][$];
   int              q_err[N][$];
   longint unsigned cur_size[N];
   int              cur_err[N];
   bit              has_msg[N];
   bit              cfg_done[N];
   int              wsent[N];
   int              msgno[N];

   // stimulus knobs: en_mode 0=low 1=high 2=random; rdy_mode 0=high 1=random 2=toggle
   int  en_mode = 1;
   int  rdy_mode = 0;
   bit  rnd_valid = 0;
   bit  tog = 0;

   // transaction-level model
   int              m_owner, m_phase, m_rr;
   longint unsigned m_left;
   bit              m_err;
   int              grant_log[$];
   int              total_words = 0;
   int              err_pulses = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned words_of(input longint unsigned s);
      if (s == 0) return 1;
      return (s + 511) / 512;
   endfunction

   function automatic logic [511:0] word_of(input int i, input int m, input int w);
      logic [31:0] x;
      x = {8'(i), 8'(m), 16'(w)};
      return {16{x}} ^ {16{32'h5a5a0000 + 32'(w * 7)}};
   endfunction

   task automatic model_reset();
      m_owner = -1; m_phase = 0; m_rr = N - 1; m_left = 0; m_err = 0;
   endtask

   task automatic bfm_clear();
      for (int i = 0; i < N; i++) begin
         q_size[i].delete(); q_err[i].delete();
         has_msg[i] = 0; cfg_done[i] = 0; wsent[i] = 0;
      end
   endtask

   task automatic drive_inputs();
      longint unsigned nw;
      for (int i = 0; i < N; i++) begin
         if (!has_msg[i] && q_size[i].size() > 0) begin
            cur_size[i] = q_size[i].pop_front();
            cur_err[i]  = q_err[i].pop_front();
            has_msg[i] = 1; cfg_done[i] = 0; wsent[i] = 0;
         end
         nw = words_of(cur_size[i]);
         req_cfg_valid[i]        = has_msg[i] && !cfg_done[i];
         req_cfg_size[64*i +: 64] = cur_size[i];
         req_cfg_scheme[2*i +: 2] = 2'(i + msgno[i]);
         req_data_valid[i] = has_msg[i] && cfg_done[i] && (!rnd_valid || ($urandom % 4 != 0));
         req_data[512*i +: 512] = word_of(i, msgno[i], wsent[i]);
         req_data_last[i] = (longint'(wsent[i]) == nw - 1) ^ (wsent[i] == cur_err[i]);
      end
      tog = ~tog;
      case (rdy_mode)
         0: begin cfg_ready = 1; data_out_ready = 1; end
         1: begin cfg_ready = ($urandom % 3 != 0); data_out_ready = ($urandom % 3 != 0); end
         default: begin cfg_ready = 1; data_out_ready = tog; end
      endcase
      case (en_mode)
         0: en = 0;
         1: en = 1;
         default: en = ($urandom % 5 != 0);
      endcase
   endtask

   task automatic push_msg(input int r, input longint unsigned s, input int e);
      q_size[r].push_back(s);
      q_err[r].push_back(e);
   endtask

   // one clock: check outputs at negedge, advance model/BFMs at posedge, redrive
   task automatic cycle();
      logic [N-1:0]   eg, ecr, edr;
      logic [63:0]    esz;
      logic [1:0]     esc;
      logic [511:0]   edat;
      bit             ecv, edv, chs, dhs, found;
      int             o, j;
      @(negedge clk);
      o = m_owner;
      eg = '0; ecr = '0; edr = '0; esz = '0; esc = '0; edat = '0;
      ecv = 0; edv = 0; chs = 0; dhs = 0;
      if (o >= 0) begin
         eg[o] = 1'b1;
         if (m_phase == 1) begin
            ecv = req_cfg_valid[o]; esz = req_cfg_size[64*o +: 64];
            esc = req_cfg_scheme[2*o +: 2]; ecr[o] = cfg_ready;
            chs = ecv && cfg_ready;
         end
         if (m_phase == 2) begin
            edv = req_data_valid[o]; edat = req_data[512*o +: 512];
            edr[o] = data_out_ready; dhs = edv && data_out_ready;
         end
      end
      chk("grant", grant, eg);
      chk("grant_onehot", $onehot0(grant), 1);
      chk("busy", busy, o >= 0);
      chk("cfg_valid", cfg_valid, ecv);
      chk("cfg_size", cfg_size, esz);
      chk("cfg_scheme", cfg_scheme, esc);
      chk("req_cfg_ready", req_cfg_ready, ecr);
      chk("data_valid", data_out_valid, edv);
      chk("data_out", data_out, edat);
      chk("data_last", data_out_last, (m_phase == 2) && (m_left == 1));
      chk("req_data_ready", req_data_ready, edr);
      chk("last_err", last_err, m_err);
      if (last_err) err_pulses++;
      if (dhs) begin
         chk("sb_word", data_out, word_of(o, msgno[o], wsent[o]));
         chk("sb_last", data_out_last, longint'(wsent[o]) == words_of(cur_size[o]) - 1);
      end
      @(posedge clk);
      if (rst || sync_rst) begin
         model_reset();
         bfm_clear();
      end else begin
         m_err = 0;
         case (m_phase)
            0: if (en) begin
               found = 0;
               for (int k = 1; k <= N; k++) begin
                  j = (m_rr + k) % N;
                  if (!found && req_cfg_valid[j]) begin
                     found = 1; m_owner = j; m_phase = 1; grant_log.push_back(j);
                  end
               end
            end
            1: if (chs) begin
               m_left = words_of(req_cfg_size[64*o +: 64]);
               m_phase = 2; cfg_done[o] = 1;
            end
            default: if (dhs) begin
               m_err = (req_data_last[o] != (m_left == 1));
               m_left--; wsent[o]++; total_words++;
               if (longint'(wsent[o]) == words_of(cur_size[o])) begin
                  $display("MSG req=%0d msg=%0d size=%0d words=%0d", o, msgno[o], cur_size[o], wsent[o]);
                  has_msg[o] = 0; msgno[o]++;
               end
               if (m_left == 0) begin
                  m_rr = o; m_owner = -1; m_phase = 0;
               end
            end
         endcase
      end
      #1;
      drive_inputs();
   endtask

   function automatic bit pending();
      bit p;
      p = (m_owner >= 0);
      for (int i = 0; i < N; i++) p |= has_msg[i] || (q_size[i].size() > 0);
      return p;
   endfunction

   task automatic run_until_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_drain"}, n < budget, 1);
   endtask

   task automatic do_async_rst();
      rst = 1;
      #1;
      model_reset();
      bfm_clear();
      drive_inputs();
      chk("rst_grant", grant, '0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_ready", req_cfg_ready, '0);
      chk("rst_data_ready", req_data_ready, '0);
      cycle();
      rst = 0;
   endtask

   int w0, e0, n;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      model_reset();
      bfm_clear();
      for (int i = 0; i < N; i++) begin msgno[i] = 0; cur_size[i] = 0; cur_err[i] = -1; end
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grant", grant, '0);
      chk("reset_busy", busy, 0);
      chk("reset_last_err", last_err, 0);
      chk("reset_data_valid", data_out_valid, 0);
      rst = 0;
      drive_inputs();
      repeat (2) cycle();

      // single message on req0
      w0 = total_words;
      push_msg(0, 512, -1); drive_inputs();
      run_until_idle("s1", 50);
      chk("s1_words", total_words - w0, 1);

      // size boundaries on req1
      w0 = total_words;
      push_msg(1, 0, -1); push_msg(1, 1, -1); push_msg(1, 513, -1); push_msg(1, 1024, -1);
      drive_inputs();
      run_until_idle("s2", 100);
      chk("s2_words", total_words - w0, 6);

      // async reset during word 2 of a 4-word message
      push_msg(3, 2048, -1); drive_inputs();
      n = 0;
      while (!(m_phase == 2 && wsent[3] == 1) && n < 50) begin cycle(); n++; end
      chk("s6_reach_word2", n < 50, 1);
      do_async_rst();
      repeat (2) cycle();

      // all four requesters contend from reset pointer
      grant_log.delete();
      push_msg(0, 100, -1); push_msg(0, 100, -1);
      push_msg(1, 100, -1); push_msg(2, 100, -1); push_msg(3, 100, -1);
      drive_inputs();
      run_until_idle("s3", 100);
      chk("s3_ngrants", grant_log.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < grant_log.size()) chk($sformatf("s3_order%0d", i), grant_log[i], exp_order[i]);

      // toggling downstream ready over a 3-word message
      w0 = total_words;
      rdy_mode = 2;
      push_msg(0, 1500, -1); drive_inputs();
      run_until_idle("s4", 100);
      chk("s4_words", total_words - w0, 3);
      rdy_mode = 0;

      // early last flag on req2
      w0 = total_words; e0 = err_pulses;
      push_msg(2, 1000, 0); drive_inputs();
      run_until_idle("s5", 50);
      repeat (2) cycle();
      chk("s5_words", total_words - w0, 2);
      chk("s5_err_pulses", err_pulses - e0, 1);

      // synchronous reset mid-message
      push_msg(1, 1536, -1); drive_inputs();
      n = 0;
      while (m_phase != 2 && n < 50) begin cycle(); n++; end
      chk("s7_reach_data", n < 50, 1);
      sync_rst = 1;
      cycle();
      sync_rst = 0;
      #1;
      chk("s7_busy", busy, 0);
      chk("s7_grant", grant, '0);

      // en low holds IDLE with requests pending
      en_mode = 0;
      push_msg(2, 300, -1); drive_inputs();
      repeat (5) cycle();
      chk("s8_en_hold_busy", busy, 0);
      en_mode = 1;
      run_until_idle("s8", 50);

      // random traffic
      en_mode = 2; rdy_mode = 1; rnd_valid = 1;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 4; k++)
            push_msg(i, longint'($urandom_range(0, 2200)), ($urandom % 6 == 0) ? 0 : -1);
      drive_inputs();
      run_until_idle("s9", 3000);
      repeat (3) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
